// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter/sequencer in front of a single 32-bit SRAM controller port.
// One request is latched at a time. It issues a single strobe, waits for an ack
// or a timeout, then returns a one-cycle ack to the granted requester.
module sram_port_arbiter #(
  parameter int unsigned FIXED_PRIO  = 0,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_p0_req,
  input  logic        i_p0_we,
  input  logic [17:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic [3:0]  i_p0_bmask,
  output logic        o_p0_ack,
  output logic        o_p0_err,
  output logic [31:0] o_p0_rdata,
  input  logic        i_p1_req,
  input  logic        i_p1_we,
  input  logic [17:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  logic [3:0]  i_p1_bmask,
  output logic        o_p1_ack,
  output logic        o_p1_err,
  output logic [31:0] o_p1_rdata,
  output logic [17:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  output logic        o_mem_wren,
  output logic        o_mem_rden,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_busy,
  output logic [1:0]  o_grant
);

  localparam int unsigned CW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam bit FIXED = (FIXED_PRIO != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          we_q;
  logic [17:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    bmask_q;
  logic [1:0]    grant_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic          last_p1_q;   // 1 = port 1 was served last
  logic          pick_p0;
  logic          any_req;
  logic          timeout;
  logic          xfer_phase;

  // Arbitration choice and next-state decode
  always_comb begin
    state_d    = state_q;
    any_req    = i_p0_req | i_p1_req;
    pick_p0    = i_p0_req & (~i_p1_req | FIXED | last_p1_q);
    timeout    = (cnt_q == CNT_LAST);
    xfer_phase = (state_q == S_ISSUE) || (state_q == S_WAIT);
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = i_mem_ack ? S_RESP : S_WAIT;
      S_WAIT:  if (i_mem_ack || timeout) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controller-side and requester-side outputs, decoded from state and latches
  always_comb begin
    o_mem_addr  = xfer_phase ? addr_q  : '0;
    o_mem_wdata = xfer_phase ? wdata_q : '0;
    o_mem_bmask = xfer_phase ? bmask_q : '0;
    o_mem_wren  = (state_q == S_ISSUE) &  we_q;
    o_mem_rden  = (state_q == S_ISSUE) & ~we_q;
    o_busy      = (state_q != S_IDLE);
    o_grant     = (state_q == S_IDLE) ? '0 : grant_q;
    o_p0_ack    = (state_q == S_RESP) & grant_q[0];
    o_p1_ack    = (state_q == S_RESP) & grant_q[1];
    o_p0_err    = o_p0_ack & err_q;
    o_p1_err    = o_p1_ack & err_q;
    o_p0_rdata  = o_p0_ack ? rdata_q : '0;
    o_p1_rdata  = o_p1_ack ? rdata_q : '0;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Request latches, timeout counter, response capture and round-robin pointer
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bmask_q   <= '0;
      grant_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      last_p1_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            grant_q <= pick_p0 ? 2'b01 : 2'b10;
            we_q    <= pick_p0 ? i_p0_we    : i_p1_we;
            addr_q  <= pick_p0 ? i_p0_addr  : i_p1_addr;
            wdata_q <= pick_p0 ? i_p0_wdata : i_p1_wdata;
            bmask_q <= pick_p0 ? i_p0_bmask : i_p1_bmask;
          end
        end
        S_ISSUE: begin
          cnt_q <= '0;
          if (i_mem_ack) begin
            rdata_q <= we_q ? '0 : i_mem_rdata;
            err_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (i_mem_ack) begin
            rdata_q <= we_q ? '0 : i_mem_rdata;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          last_p1_q <= grant_q[1];
        end
        default: ;
      endcase
    end
  end

endmodule
